// File: rtl/gb2312_glyph_renderer.sv
// rtl/gb2312_glyph_renderer.sv - GB2312 code to coloured pixel stream renderer
//
// Fetches FONT_H font rows from an external ROM for one GB2312 glyph and streams
// the glyph as pixels, with optional 2x scaling and clipping to the screen.
// Optional build macro: GLYPH_TRANSPARENT_BG_EN (clear bits are not presented).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   char_code, x_pos, y_pos     glyph code (hi=zone, lo=position) and top-left corner
//   fg_color, bg_color, scale2x colours for set/clear bits, 2x2 block scaling
//   start, busy, done, err_code request handshake; err_code=1 for a bad code
//   rom_rd, rom_addr, rom_data  font ROM row read, data valid 1 cycle after rom_rd
//   pix_valid, pix_ready        pixel stream handshake
//   pix_x, pix_y, pix_color     pixel coordinates and RGB565 colour

module gb2312_glyph_renderer #(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 320,
    parameter int FONT_W   = 24,
    parameter int FONT_H   = 24,
    parameter int COORD_W  = 10,
    parameter int ROM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        char_code,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [15:0]        fg_color,
    input  logic [15:0]        bg_color,
    input  logic               scale2x,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err_code,
    output logic               rom_rd,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [FONT_W-1:0]  rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color
);

    localparam int CW = $clog2(2 * FONT_W + 1);
    localparam int LW = $clog2(2 * FONT_H + 1);
    localparam int RW = $clog2(FONT_H + 1);
    // One extra bit so x0+col / y0+line never wrap back onto the screen.
    localparam int XW = COORD_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_CAP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [15:0]        code_r;
    logic [COORD_W-1:0] x0_r, y0_r;
    logic [15:0]        fg_r, bg_r;
    logic               s2_r;
    logic [ROM_AW-1:0]  base_r;
    logic [RW-1:0]      row_r;
    logic [LW-1:0]      line_r;
    logic [CW-1:0]      col_r;
    logic [FONT_W-1:0]  row_buf;
    logic               err_r;

    logic               code_ok;
    logic [ROM_AW-1:0]  zone_off, pos_off, glyph_idx, glyph_base, fetch_addr;
    logic [XW-1:0]      px, py;
    logic [CW-1:0]      cidx;
    logic [FONT_W-1:0]  shifted;
    logic               bit_on, clip, skip, last_col, last_row, repeat_line, step;

    assign code_ok = (code_r[15:8] >= 8'hA1) && (code_r[15:8] <= 8'hF7) &&
                     (code_r[7:0]  >= 8'hA1) && (code_r[7:0]  <= 8'hFE);

    assign zone_off   = ROM_AW'(code_r[15:8]) - ROM_AW'(8'hA1);
    assign pos_off    = ROM_AW'(code_r[7:0])  - ROM_AW'(8'hA1);
    assign glyph_idx  = zone_off * ROM_AW'(94) + pos_off;
    assign glyph_base = glyph_idx * ROM_AW'(FONT_H);
    assign fetch_addr = base_r + ROM_AW'(row_r);

    assign px = XW'(x0_r) + XW'(col_r);
    assign py = XW'(y0_r) + XW'(line_r);

    // Font column = col/S; shifting left puts that bit at the MSB.
    assign cidx    = s2_r ? (col_r >> 1) : col_r;
    assign shifted = row_buf << cidx;
    assign bit_on  = shifted[FONT_W-1];

    assign clip = (px >= XW'(SCREEN_W)) || (py >= XW'(SCREEN_H));
`ifdef GLYPH_TRANSPARENT_BG_EN
    assign skip = clip || !bit_on;
`else
    assign skip = clip;
`endif

    assign last_col    = (col_r == (s2_r ? CW'(2 * FONT_W - 1) : CW'(FONT_W - 1)));
    assign last_row    = (row_r == RW'(FONT_H - 1));
    // In 2x mode the even line of a pair reuses the buffered font row.
    assign repeat_line = s2_r && !line_r[0];
    assign step        = (state == S_EMIT) && (skip || pix_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CHECK;
            S_CHECK: state_nx = code_ok ? S_FETCH : S_DONE;
            S_FETCH: state_nx = S_CAP;
            S_CAP:   state_nx = S_EMIT;
            S_EMIT: begin
                if (step && last_col) begin
                    if (repeat_line)   state_nx = S_EMIT;
                    else if (last_row) state_nx = S_DONE;
                    else               state_nx = S_FETCH;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_r  <= '0;
            x0_r    <= '0;
            y0_r    <= '0;
            fg_r    <= '0;
            bg_r    <= '0;
            s2_r    <= 1'b0;
            base_r  <= '0;
            row_r   <= '0;
            line_r  <= '0;
            col_r   <= '0;
            row_buf <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        code_r <= char_code;
                        x0_r   <= x_pos;
                        y0_r   <= y_pos;
                        fg_r   <= fg_color;
                        bg_r   <= bg_color;
                        s2_r   <= scale2x;
                        err_r  <= 1'b0;
                        row_r  <= '0;
                        line_r <= '0;
                        col_r  <= '0;
                    end
                end
                S_CHECK: begin
                    if (!code_ok) err_r <= 1'b1;
                    base_r <= glyph_base;
                end
                S_CAP: begin
                    row_buf <= rom_data;
                    col_r   <= '0;
                end
                S_EMIT: begin
                    if (step) begin
                        if (last_col) begin
                            col_r  <= '0;
                            line_r <= line_r + LW'(1);
                            if (!repeat_line && !last_row) row_r <= row_r + RW'(1);
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign err_code  = err_r;
    assign rom_rd    = (state == S_FETCH);
    assign rom_addr  = rom_rd ? fetch_addr : '0;
    assign pix_valid = (state == S_EMIT) && !skip;
    assign pix_x     = pix_valid ? px[COORD_W-1:0] : '0;
    assign pix_y     = pix_valid ? py[COORD_W-1:0] : '0;
    assign pix_color = pix_valid ? (bit_on ? fg_r : bg_r) : 16'h0000;

endmodule

// File: tb/tb_gb2312_glyph_renderer.sv
// tb/tb_gb2312_glyph_renderer.sv - scoreboard bench for gb2312_glyph_renderer

module tb_gb2312_glyph_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] char_code;
    logic [9:0]  x_pos, y_pos;
    logic [15:0] fg_color, bg_color;
    logic        scale2x, start;
    logic        busy, done, err_code, rom_rd;
    logic [17:0] rom_addr;
    logic [23:0] rom_data = 24'h0;
    logic        pix_valid, pix_ready;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_color;

    always #5 clk = ~clk;

    gb2312_glyph_renderer dut (
        .clk(clk), .rst_n(rst_n), .char_code(char_code), .x_pos(x_pos), .y_pos(y_pos),
        .fg_color(fg_color), .bg_color(bg_color), .scale2x(scale2x), .start(start),
        .busy(busy), .done(done), .err_code(err_code), .rom_rd(rom_rd),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];
    int rom_cnt, done_cnt, pix_cnt, pushed_n;
    logic [17:0] first_addr;
    logic stall_pend = 1'b0;
    logic [35:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rom_fn(input logic [17:0] a);
        logic [31:0] w;
        w = {14'd0, a} * 32'h9E3779B1;
        return w[31:8] ^ {6'd0, a};
    endfunction

    // Font ROM: data valid exactly one cycle after the read strobe, noise otherwise.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_fn(rom_addr);
        else        rom_data <= 24'($urandom);
    end

    task automatic push_glyph(input logic [17:0] base, input int x0, input int y0,
                              input logic [15:0] fg, input logic [15:0] bg, input bit s2);
        int s, x, y;
        logic [23:0] w;
        bit b;
        s = s2 ? 2 : 1;
        for (int ln = 0; ln < 24 * s; ln++) begin
            w = rom_fn(base + 18'(ln / s));
            for (int c = 0; c < 24 * s; c++) begin
                b = w[23 - c / s];
                x = x0 + c;
                y = y0 + ln;
`ifdef GLYPH_TRANSPARENT_BG_EN
                if (x < 240 && y < 320 && b) begin
`else
                if (x < 240 && y < 320) begin
`endif
                    exp_q.push_back({10'(x), 10'(y), b ? fg : bg});
                    pushed_n++;
                end
            end
        end
    endtask

    // Monitor: ROM/done counters, stall stability and pixel scoreboard.
    always @(negedge clk) begin
        if (rom_rd) begin
            rom_cnt++;
            if (rom_cnt == 1) first_addr = rom_addr;
        end
        if (done) done_cnt++;
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) check("stall_hold", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, held});
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_pixel: got %0h expected none", {pix_x, pix_y, pix_color});
                end else begin
                    check("pixel", {pix_x, pix_y, pix_color}, exp_q.pop_front());
                end
            end
            stall_pend = pix_valid && !pix_ready;
            held = {pix_x, pix_y, pix_color};
        end
    end

    task automatic clear_counters();
        rom_cnt = 0; done_cnt = 0; pix_cnt = 0; pushed_n = 0; first_addr = '1;
    endtask

    task automatic start_glyph(input logic [15:0] code, input logic [9:0] x, input logic [9:0] y,
                               input logic [15:0] fg, input logic [15:0] bg, input logic s2);
        char_code = code; x_pos = x; y_pos = y;
        fg_color = fg; bg_color = bg; scale2x = s2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready=1; mode 1: 30% ready plus a 50-cycle stall; mode 2: start pulses while busy.
    task automatic run_until_done(input int mode, input int budget, output int cycles, output bit got);
        got = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; cycles = i; end
            @(posedge clk); #1;
            if (got) break;
            if (mode == 1) pix_ready = (i >= 200 && i < 250) ? 1'b0 : ($urandom_range(0, 99) < 30);
            if (mode == 2) begin
                if (i >= 50 && i < 54) begin
                    start = 1'b1; char_code = 16'hA1A1; x_pos = 10'd100;
                end else begin
                    start = 1'b0;
                end
            end
        end
        pix_ready = 1'b1;
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic check_glyph(input string tag, input int exp_rom, input logic [17:0] exp_addr,
                               input int exp_pix);
        check({tag, "_err"}, err_code, 0);
        check({tag, "_rom_rd"}, rom_cnt, exp_rom);
        check({tag, "_first_addr"}, first_addr, exp_addr);
`ifdef GLYPH_TRANSPARENT_BG_EN
        check({tag, "_pix_popcount"}, pix_cnt, pushed_n);
`else
        check({tag, "_pix_count"}, pix_cnt, exp_pix);
`endif
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        bit got;
        rst_n = 1'b0; start = 1'b0; char_code = '0; x_pos = '0; y_pos = '0;
        fg_color = '0; bg_color = '0; scale2x = 1'b0; pix_ready = 1'b1;
        clear_counters();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_rom", {rom_rd, rom_addr}, 0);
        check("rst_pix", {pix_valid, pix_x, pix_y, pix_color}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1x glyph at origin, with start pulses while busy that must be ignored.
        clear_counters();
        push_glyph(18'd33840, 0, 0, 16'hF800, 16'h001F, 1'b0);
        start_glyph(16'hB0A1, 10'd0, 10'd0, 16'hF800, 16'h001F, 1'b0);
        run_until_done(2, 2000, cyc, got);
        repeat (2) @(posedge clk);
        #1;
        check_glyph("basic", 24, 18'd33840, 576);
        check("basic_done_pulses", done_cnt, 1);

        // Invalid zone; a start during the DONE cycle must be ignored.
        clear_counters();
        start_glyph(16'hA0A1, 10'd0, 10'd0, 16'hF800, 16'h001F, 1'b0);
        @(posedge clk); #1;
        char_code = 16'hA1A1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_cycle_start_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("bad_zone_err", err_code, 1);
        check("bad_zone_rom", rom_cnt, 0);
        check("bad_zone_pix", pix_cnt, 0);
        check("bad_zone_done", done_cnt, 1);

        // Invalid position: done two cycles after start.
        clear_counters();
        start_glyph(16'hB0FF, 10'd0, 10'd0, 16'hF800, 16'h001F, 1'b0);
        run_until_done(0, 20, cyc, got);
        check("bad_pos_latency", cyc, 2);
        check("bad_pos_err", err_code, 1);
        check("bad_pos_rom", rom_cnt, 0);
        check("bad_pos_pix", pix_cnt, 0);

        // 2x glyph started in the cycle right after done.
        clear_counters();
        push_glyph(18'd0, 10, 20, 16'h07E0, 16'hFFE0, 1'b1);
        start_glyph(16'hA1A1, 10'd10, 10'd20, 16'h07E0, 16'hFFE0, 1'b1);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_err_cleared", err_code, 0);
        run_until_done(0, 4000, cyc, got);
        check_glyph("scale2x", 24, 18'd0, 2304);

        // Clipping at the bottom-right corner.
        clear_counters();
        push_glyph(18'd33840, 230, 310, 16'h1234, 16'hABCD, 1'b0);
        start_glyph(16'hB0A1, 10'd230, 10'd310, 16'h1234, 16'hABCD, 1'b0);
        run_until_done(0, 1000, cyc, got);
        check_glyph("clip", 24, 18'd33840, 100);

        // Backpressure: same expected stream as the ready=1 run.
        clear_counters();
        push_glyph(18'd33840, 0, 0, 16'hF800, 16'h001F, 1'b0);
        start_glyph(16'hB0A1, 10'd0, 10'd0, 16'hF800, 16'h001F, 1'b0);
        run_until_done(1, 4000, cyc, got);
        check_glyph("backpressure", 24, 18'd33840, 576);

        // Reset in the middle of emission.
        clear_counters();
        push_glyph(18'd33840, 0, 0, 16'hF800, 16'h001F, 1'b0);
        start_glyph(16'hB0A1, 10'd0, 10'd0, 16'hF800, 16'h001F, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        pix_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_busy_done", {busy, done}, 0);
        check("midrst_rom", {rom_rd, rom_addr}, 0);
        check("midrst_pix", {pix_valid, pix_x, pix_y, pix_color}, 0);
        exp_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb2312_glyph_renderer.md
Name: gb2312_glyph_renderer

Overview:
- Second-generation GB2312 glyph renderer: converts a GB2312 code into a stream of coloured pixels for the ST7789 SPI memory-controller pixel port.
- Additions over the first-generation writer: correct zone/position glyph indexing, external font-ROM port, valid/ready backpressure, programmable fg/bg colours, 1x/2x scaling, screen clipping, invalid-code detection.
- Sits between the text/console layer and the pixel-write arbiter.

Parameters:
- SCREEN_W, 240, screen width in pixels
- SCREEN_H, 320, screen height in pixels
- FONT_W, 24, glyph width in bits per ROM word (1..32)
- FONT_H, 24, glyph rows per glyph
- COORD_W, 10, width of coordinate ports
- ROM_AW, 18, font-ROM address width; must hold 8178*FONT_H-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- char_code  in  16  GB2312 code, hi byte = zone, lo byte = position; sampled on accepted start
- x_pos  in  COORD_W  glyph top-left X; sampled on accepted start
- y_pos  in  COORD_W  glyph top-left Y; sampled on accepted start
- fg_color  in  16  RGB565 colour for set bits; sampled on accepted start
- bg_color  in  16  RGB565 colour for clear bits; sampled on accepted start
- scale2x  in  1  1 = each font bit drawn as a 2x2 block; sampled on accepted start
- start  in  1  render request; accepted only when busy=0
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the glyph completes or is rejected
- err_code  out  1  valid with done; 1 = char_code outside the GB2312 range
- rom_rd  out  1  font-ROM read strobe, one cycle
- rom_addr  out  ROM_AW  font-ROM row address
- rom_data  in  FONT_W  row bits, MSB = leftmost pixel, valid exactly 1 cycle after rom_rd
- pix_valid  out  1  pixel present
- pix_ready  in  1  sink accepts pixel
- pix_x  out  COORD_W  pixel X
- pix_y  out  COORD_W  pixel Y
- pix_color  out  16  pixel colour

Behaviour:
- Reset (rst_n=0 on a clk edge): all outputs are 0 and the FSM is IDLE. Reset in any state aborts the glyph immediately and produces no done pulse.
- Code check: hi must be in 0xA1..0xF7 and lo in 0xA1..0xFE. If not, go to DONE with err_code=1; no ROM read and no pixels.
- Glyph index: idx = (hi-0xA1)*94 + (lo-0xA1), range 0..8177.
- Row address: rom_addr = idx*FONT_H + row, computed with ROM_AW-bit unsigned arithmetic.
- Scale factor S = 2 if scale2x else 1. Output is FONT_W*S columns by FONT_H*S lines.
- FSM states:
  - IDLE: on start, latch all sampled inputs, set busy, go to CHECK.
  - CHECK: go to DONE (invalid) or FETCH.
  - FETCH: rom_rd=1 with rom_addr for the current font row; go to CAP.
  - CAP: register rom_data into the row shift buffer; set col=0; go to EMIT.
  - EMIT: one screen pixel per step, see below.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- EMIT pixel values:
  - pix_x = x0 + col, pix_y = y0 + line.
  - Pixel colour is fg_color if buffer bit [FONT_W-1 - col/S] is set, else bg_color.
- EMIT handshake:
  - pix_valid stays high, and x/y/color stay stable, until pix_valid&&pix_ready; the step advances on that cycle.
  - Maximum throughput is 1 pixel/clk with pix_ready tied high.
- Clipping:
  - A pixel with pix_x>=SCREEN_W or pix_y>=SCREEN_H is never presented (pix_valid=0) and advances in 1 cycle.
  - Coordinates are computed one bit wider than COORD_W, so there is no wrap-around.
- End of line:
  - After col = FONT_W*S-1, go to the next line.
  - With S=2 and an even line, the same buffer is re-emitted without a refetch.
  - Otherwise the next font row goes to FETCH, or, if the last row is done, to DONE.
- ROM cost: exactly FONT_H rom_rd pulses per valid glyph regardless of S.
- start while busy=1 is ignored, including in the DONE cycle.
- Back-to-back: start in the cycle after done is accepted.
- err_code holds its value until the next accepted start.

Optional Feature:
- Macro: GLYPH_TRANSPARENT_BG_EN.
- Defined: pixels whose bit is 0 are treated like clipped pixels (not presented, 1 cycle each), so only foreground pixels reach the sink; bg_color is unused.
- Undefined: every in-screen pixel is presented with fg_color or bg_color.

Test Plan:
- Valid glyph, x=0, y=0, 1x, ready=1:
  - Code 0xB0A1 -> idx 1410 (15*94+0).
  - First rom_addr 33840, 24 rom_rd pulses, 576 pixels.
  - Colours match the ROM model bit-for-bit, then one done pulse with err_code=0.
- Invalid code 0xA0A1, and separately 0xB0FF -> no rom_rd, no pix_valid; done with err_code=1, 2 cycles after start.
- 2x scale, code 0xA1A1 at (10,20) -> 2304 pixels spanning x 10..57, y 20..67; 24 rom_rd pulses; each ROM bit appears as an identical 2x2 block.
- Clipping at (230,310), 1x -> only x 230..239 and y 310..319 are presented (100 pixels); done still asserts.
- Backpressure: pix_ready random at 30%, plus a 50-cycle stall mid-row -> pixel sequence identical to the ready=1 run; outputs stable during the stall.
- Reset mid-EMIT, then start asserted while busy -> after reset all outputs are 0 with no done pulse; a start while busy has no effect on the current stream.
- Transparent build (GLYPH_TRANSPARENT_BG_EN defined) -> the presented-pixel count equals the popcount of the glyph's ROM bits.
